reparto_carga: RTL and testbench
================================

REPARTO_CARGA -- requirements
Module: reparto_carga

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port solicitud_valida, input, 1 bit: a distribution request is present.
REQ-004 The block SHALL have port carga_total, input, 5 bits: the total charge to distribute across the two batteries.
REQ-005 The block SHALL have port listo, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port carga_bateria1, output, 4 bits: current charge of battery 1.
REQ-007 The block SHALL have port carga_bateria2, output, 4 bits: current charge of battery 2.
REQ-008 The block SHALL have port ocupado, output, 1 bit: distribution is in progress.
REQ-009 The block SHALL have port fin, output, 1 bit: one-cycle pulse marking distribution complete.
REQ-010 The block SHALL have port exceso, output, 1 bit: the request exceeded capacity; this port is present only under EXCESO_EN.

Function
REQ-011 The block SHALL implement three states: REPOSO, CARGA, FIN.
REQ-012 listo SHALL equal 1 exactly when the state is REPOSO.
REQ-013 ocupado SHALL equal 1 exactly when the state is CARGA.
REQ-014 fin SHALL equal 1 exactly when the state is FIN.
REQ-015 A request SHALL be accepted on a rising edge where solicitud_valida=1 and listo=1.
REQ-016 On acceptance, the block SHALL latch objetivo = min(carga_total, 30), clear both battery outputs to 0, and enter CARGA.
REQ-017 solicitud_valida SHALL be ignored outside REPOSO; no queuing and no effect on the operation in progress.
REQ-018 On each edge in CARGA, if carga_bateria1+carga_bateria2 (5-bit sum) equals objetivo, the block SHALL enter FIN with no increment.
REQ-019 Otherwise, on each edge in CARGA, the block SHALL increment by 1 the battery with the lower charge; on a tie it SHALL increment battery 1.
REQ-020 Battery values SHALL never exceed 15 and SHALL never wrap, since objetivo <= 30 guarantees this.
REQ-021 For objetivo N, latency SHALL be:
- accept edge, then N increment edges, then one edge into FIN;
- fin high for the single cycle after edge N+1;
- next edge returns to REPOSO.
REQ-022 For objetivo 0, the block SHALL enter FIN on the first edge after acceptance, with both batteries at 0.
REQ-023 The final result SHALL be carga_bateria1 = ceil(N/2) and carga_bateria2 = floor(N/2).
REQ-024 Battery outputs SHALL hold their final values in FIN and REPOSO until the next acceptance.
REQ-025 A request arriving in the same cycle as fin=1 SHALL NOT be accepted; it is accepted only once listo=1.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk:
- force the state to REPOSO;
- force carga_bateria1=0, carga_bateria2=0, ocupado=0, fin=0, listo=1;
- force exceso=0 when present;
- force the latched objetivo to 0.
REQ-027 Reset asserted mid-CARGA or mid-FIN SHALL abort the operation with no fin pulse.
REQ-028 The first acceptance after reset release SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-029 With macro EXCESO_EN defined:
- the exceso port SHALL exist;
- it SHALL be set on acceptance when carga_total=31, else cleared on acceptance;
- it SHALL hold until the next acceptance or reset.
REQ-030 Without EXCESO_EN:
- the exceso port and its register SHALL be absent;
- carga_total=31 SHALL saturate silently to 30;
- all other behaviour SHALL be identical.

Verification
REQ-031 Request carga_total=8 (3+5) -> ocupado high for 9 cycles, fin pulse once, final b1=4, b2=4, listo high the following cycle.
REQ-032 Request carga_total=15 (7+8) -> 15 increments in the sequence b1, b2, b1, ..., final b1=8, b2=7, fin on the cycle after edge 16.
REQ-033 Request carga_total=30 (15+15) -> final b1=15, b2=15, no wrap; exceso=0 with EXCESO_EN.
REQ-034 Request carga_total=31 -> final b1=15, b2=15; exceso=1 with EXCESO_EN; build without the macro yields the same battery values.
REQ-035 Request 0 -> fin pulse on the cycle after the first post-accept edge, batteries 0, then back-to-back request 5 -> b1=3, b2=2.
REQ-036 rst_n pulled low at the 4th CARGA cycle of request 10 -> outputs 0 and listo=1 immediately, no fin; new request 6 after release -> b1=3, b2=3.

Source files
------------

// File: rtl/reparto_carga.sv
// Charge distributor: fills two 4-bit batteries one unit per cycle, always topping up the
// lower one (battery 1 on ties). Optional EXCESO_EN adds an over-capacity request flag.
module reparto_carga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       solicitud_valida,
  input  logic [4:0] carga_total,
  output logic       listo,
  output logic [3:0] carga_bateria1,
  output logic [3:0] carga_bateria2,
  output logic       ocupado,
  output logic       fin
`ifdef EXCESO_EN
  ,
  output logic       exceso
`endif
);

  // state  | meaning
  // REPOSO | idle, battery values held, request accepted
  // CARGA  | one battery incremented per edge until sum reaches objetivo
  // FIN    | one-cycle completion pulse, requests ignored
  typedef enum logic [1:0] {REPOSO, CARGA, FIN} estado_t;

  estado_t    estado, estado_sig;
  logic [4:0] objetivo;
  logic [4:0] suma;
  logic       aceptar;
  logic       completo;

  assign suma     = {1'b0, carga_bateria1} + {1'b0, carga_bateria2};
  assign completo = (suma == objetivo);
  assign aceptar  = (estado == REPOSO) && solicitud_valida;

  assign listo   = (estado == REPOSO);
  assign ocupado = (estado == CARGA);
  assign fin     = (estado == FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:  if (solicitud_valida) estado_sig = CARGA;
      CARGA:   if (completo)         estado_sig = FIN;
      FIN:                           estado_sig = REPOSO;
      default:                       estado_sig = REPOSO;
    endcase
  end

  // Capping objetivo at 30 keeps each battery at or below 15, so no wrap is possible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      objetivo       <= 5'd0;
      carga_bateria1 <= 4'd0;
      carga_bateria2 <= 4'd0;
    end else if (aceptar) begin
      objetivo       <= (carga_total == 5'd31) ? 5'd30 : carga_total;
      carga_bateria1 <= 4'd0;
      carga_bateria2 <= 4'd0;
    end else if ((estado == CARGA) && !completo) begin
      if (carga_bateria1 <= carga_bateria2) carga_bateria1 <= carga_bateria1 + 4'd1;
      else                                  carga_bateria2 <= carga_bateria2 + 4'd1;
    end
  end

`ifdef EXCESO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       exceso <= 1'b0;
    else if (aceptar) exceso <= (carga_total == 5'd31);
  end
`endif

endmodule

// File: tb/tb_reparto_carga.sv
// Self-checking bench for reparto_carga: directed cases, mid-run reset and randomized
// requests checked against a per-cycle expected battery trajectory.
module tb_reparto_carga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       solicitud_valida;
  logic [4:0] carga_total;
  logic       listo, ocupado, fin;
  logic [3:0] carga_bateria1, carga_bateria2;
`ifdef EXCESO_EN
  logic       exceso;
`endif

  int n_vec = 0;
  int n_err = 0;

  reparto_carga dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .solicitud_valida (solicitud_valida),
    .carga_total      (carga_total),
    .listo            (listo),
    .carga_bateria1   (carga_bateria1),
    .carga_bateria2   (carga_bateria2),
    .ocupado          (ocupado),
    .fin              (fin)
`ifdef EXCESO_EN
    ,
    .exceso           (exceso)
`endif
  );

  always #5 clk = ~clk;

  // Packed view {ocupado, fin, listo, b1, b2}
  function automatic logic [10:0] vista(input logic o, input logic f, input logic l,
                                        input int b1, input int b2);
    return {o, f, l, 4'(b1), 4'(b2)};
  endfunction

  // Called at a negedge with the block idle; returns at a negedge back in REPOSO.
  // Model: after k increments battery 1 holds ceil(k/2), battery 2 floor(k/2).
  task automatic do_req(input logic [4:0] ct, input bit ruido, input string nombre);
    int n;
    logic [10:0] obs;
    n = (ct > 5'd30) ? 30 : int'(ct);
    n_vec++;
    if (listo !== 1'b1) begin
      n_err++;
      $display("FAIL %s listo_before_req got=%b want=1", nombre, listo);
    end
    solicitud_valida = 1'b1;
    carga_total      = ct;
    @(negedge clk);
    for (int k = 0; k <= n; k++) begin
      obs = {ocupado, fin, listo, carga_bateria1, carga_bateria2};
      n_vec++;
      if (obs !== vista(1'b1, 1'b0, 1'b0, (k + 1) / 2, k / 2)) begin
        n_err++;
        $display("FAIL %s carga_step%0d got=%h want=%h", nombre, k, obs,
                 vista(1'b1, 1'b0, 1'b0, (k + 1) / 2, k / 2));
      end
      solicitud_valida = ruido ? 1'($urandom_range(0, 1)) : 1'b0;
      carga_total      = 5'($urandom_range(0, 31));
      @(negedge clk);
    end
    obs = {ocupado, fin, listo, carga_bateria1, carga_bateria2};
    n_vec++;
    if (obs !== vista(1'b0, 1'b1, 1'b0, (n + 1) / 2, n / 2)) begin
      n_err++;
      $display("FAIL %s fin_state got=%h want=%h", nombre, obs,
               vista(1'b0, 1'b1, 1'b0, (n + 1) / 2, n / 2));
    end
`ifdef EXCESO_EN
    n_vec++;
    if (exceso !== (ct == 5'd31)) begin
      n_err++;
      $display("FAIL %s exceso got=%b want=%b", nombre, exceso, (ct == 5'd31));
    end
`endif
    // A request present during fin must not be taken.
    solicitud_valida = 1'b1;
    carga_total      = 5'd7;
    @(negedge clk);
    obs = {ocupado, fin, listo, carga_bateria1, carga_bateria2};
    n_vec++;
    if (obs !== vista(1'b0, 1'b0, 1'b1, (n + 1) / 2, n / 2)) begin
      n_err++;
      $display("FAIL %s back_to_reposo got=%h want=%h", nombre, obs,
               vista(1'b0, 1'b0, 1'b1, (n + 1) / 2, n / 2));
    end
    solicitud_valida = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rst_n = 1'b0; solicitud_valida = 1'b1; carga_total = 5'd9;
    #3;
    obs = {ocupado, fin, listo, carga_bateria1, carga_bateria2};
    n_vec++;
    if (obs !== vista(1'b0, 1'b0, 1'b1, 0, 0)) begin
      n_err++;
      $display("FAIL reset_state got=%h want=%h", obs, vista(1'b0, 1'b0, 1'b1, 0, 0));
    end
    @(negedge clk);
    obs = {ocupado, fin, listo, carga_bateria1, carga_bateria2};
    n_vec++;
    if (obs !== vista(1'b0, 1'b0, 1'b1, 0, 0)) begin
      n_err++;
      $display("FAIL reset_held got=%h want=%h", obs, vista(1'b0, 1'b0, 1'b1, 0, 0));
    end
    solicitud_valida = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    do_req(5'd8,  1'b0, "req8");
    do_req(5'd15, 1'b1, "req15");
    do_req(5'd30, 1'b0, "req30");
    do_req(5'd31, 1'b0, "req31");
  endtask

  task automatic test_back_to_back();
    do_req(5'd0, 1'b0, "req0");
    do_req(5'd5, 1'b0, "req5_b2b");
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    bit vio_fin = 1'b0;
    solicitud_valida = 1'b1;
    carga_total      = 5'd10;
    @(negedge clk);
    solicitud_valida = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {ocupado, fin, listo, carga_bateria1, carga_bateria2};
    n_vec++;
    if (obs !== vista(1'b0, 1'b0, 1'b1, 0, 0)) begin
      n_err++;
      $display("FAIL reset_mid got=%h want=%h", obs, vista(1'b0, 1'b0, 1'b1, 0, 0));
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (fin) vio_fin = 1'b1;
    end
    n_vec++;
    if (vio_fin) begin
      n_err++;
      $display("FAIL reset_mid_no_fin got=1 want=0");
    end
`ifdef EXCESO_EN
    n_vec++;
    if (exceso !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_exceso got=%b want=0", exceso);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_req(5'd6, 1'b0, "req6_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_req(5'($urandom_range(0, 31)), 1'b1, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    solicitud_valida = 1'b0;
    carga_total      = 5'd0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
